// File: rtl/id_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_operand_stage
// Description : RV32I decode/operand stage with regfile bypass, busy
//               scoreboard for RAW/WAW stalls, and a valid/ready output register.
// Revision    : 1.0 - initial release
// ============================================================================
module id_operand_stage #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk_regs,
    input  logic            rst_n,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [XLEN-1:0] if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic [4:0]      R_ADDR_A,
    output logic [4:0]      R_ADDR_B,
    input  logic [XLEN-1:0] R_Data_A,
    input  logic [XLEN-1:0] R_Data_B,
    input  logic            wb_we,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_op_a,
    output logic [XLEN-1:0] ex_op_b,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rd,
    output logic            ex_rd_we,
    output logic [6:0]      ex_opcode,
    output logic [2:0]      ex_funct3,
    output logic            ex_funct7b5,
    output logic            ex_illegal
);

    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OP_OP     = 7'b0110011;
    localparam logic [6:0] c_OP_FENCE  = 7'b0001111;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

    logic [6:0]      w_opcode;
    logic [4:0]      w_rs1, w_rs2, w_rd;
    logic            w_legal, w_use_rs1, w_use_rs2, w_writes, w_rd_we;
    logic [XLEN-1:0] w_imm, w_op_a, w_op_b;
    logic            w_byp_a, w_byp_b, w_byp_rd, w_hazard, w_accept;
    logic [NREG-1:0] r_busy, w_busy_nxt;

    logic            r_valid, r_rd_we, r_funct7b5, r_illegal;
    logic [XLEN-1:0] r_pc, r_op_a, r_op_b, r_imm;
    logic [4:0]      r_rd;
    logic [6:0]      r_opcode;
    logic [2:0]      r_funct3;

    assign w_opcode = if_instr[6:0];
    assign w_rd     = if_instr[11:7];
    assign w_rs1    = if_instr[19:15];
    assign w_rs2    = if_instr[24:20];
    assign R_ADDR_A = w_rs1;
    assign R_ADDR_B = w_rs2;

    always_comb begin
        w_legal   = 1'b1;
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b0;
        w_writes  = 1'b0;
        w_imm     = '0;
        case (w_opcode)
            c_OP_LUI, c_OP_AUIPC: begin
                w_use_rs1 = 1'b0;
                w_writes  = 1'b1;
                w_imm     = {if_instr[31:12], 12'b0};
            end
            c_OP_JAL: begin
                w_use_rs1 = 1'b0;
                w_writes  = 1'b1;
                w_imm     = {{12{if_instr[31]}}, if_instr[19:12], if_instr[20],
                             if_instr[30:21], 1'b0};
            end
            c_OP_JALR, c_OP_LOAD, c_OP_OPIMM: begin
                w_writes = 1'b1;
                w_imm    = {{20{if_instr[31]}}, if_instr[31:20]};
            end
            c_OP_OP: begin
                w_use_rs2 = 1'b1;
                w_writes  = 1'b1;
            end
            c_OP_STORE: begin
                w_use_rs2 = 1'b1;
                w_imm     = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            end
            c_OP_BRANCH: begin
                w_use_rs2 = 1'b1;
                w_imm     = {{20{if_instr[31]}}, if_instr[7], if_instr[30:25],
                             if_instr[11:8], 1'b0};
            end
            c_OP_FENCE, c_OP_SYSTEM: begin
                w_imm = {{20{if_instr[31]}}, if_instr[31:20]};
            end
            default: begin
                w_legal   = 1'b0;
                w_use_rs1 = 1'b0;
            end
        endcase
    end

    assign w_rd_we  = w_writes && (w_rd != 5'd0);
    assign w_byp_a  = wb_we && (wb_addr == w_rs1);
    assign w_byp_b  = wb_we && (wb_addr == w_rs2);
    assign w_byp_rd = wb_we && (wb_addr == w_rd);

    assign w_op_a = (!w_use_rs1 || w_rs1 == 5'd0) ? '0 : (w_byp_a ? wb_data : R_Data_A);
    assign w_op_b = (!w_use_rs2 || w_rs2 == 5'd0) ? '0 : (w_byp_b ? wb_data : R_Data_B);

    assign w_hazard = (w_use_rs1 && r_busy[w_rs1] && !w_byp_a)
                   || (w_use_rs2 && r_busy[w_rs2] && !w_byp_b)
                   || (w_rd_we   && r_busy[w_rd]  && !w_byp_rd);

    assign if_ready = !flush && !w_hazard && (!r_valid || ex_ready);
    assign w_accept = if_valid && if_ready;

    // Clears are applied before the set so a new writer wins over a retiring one.
    always_comb begin
        w_busy_nxt = r_busy;
        if (flush && r_valid && r_rd_we)
            w_busy_nxt[r_rd] = 1'b0;
        if (wb_we)
            w_busy_nxt[wb_addr] = 1'b0;
        if (w_accept && w_rd_we)
            w_busy_nxt[w_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk_regs or negedge rst_n) begin
        if (!rst_n)
            r_busy <= '0;
        else
            r_busy <= w_busy_nxt;
    end

    always_ff @(posedge clk_regs or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_imm      <= '0;
            r_rd       <= '0;
            r_rd_we    <= 1'b0;
            r_opcode   <= '0;
            r_funct3   <= '0;
            r_funct7b5 <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid    <= 1'b1;
            r_pc       <= if_pc;
            r_op_a     <= w_op_a;
            r_op_b     <= w_op_b;
            r_imm      <= w_imm;
            r_rd       <= w_rd;
            r_rd_we    <= w_rd_we;
            r_opcode   <= w_opcode;
            r_funct3   <= if_instr[14:12];
            r_funct7b5 <= if_instr[30];
            r_illegal  <= !w_legal;
        end else if (ex_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign ex_valid    = r_valid;
    assign ex_pc       = r_pc;
    assign ex_op_a     = r_op_a;
    assign ex_op_b     = r_op_b;
    assign ex_imm      = r_imm;
    assign ex_rd       = r_rd;
    assign ex_rd_we    = r_rd_we;
    assign ex_opcode   = r_opcode;
    assign ex_funct3   = r_funct3;
    assign ex_funct7b5 = r_funct7b5;
    assign ex_illegal  = r_illegal;

endmodule
`default_nettype wire
